serial_adder_ctrl: RTL

//   Bit-serial adder for the lab board. Drives a 1-bit full-adder cell LSB-first from

---
 rtl/serial_adder_ctrl_pkg.sv | 12 +
 rtl/serial_adder_ctrl_fa_cell.sv | 13 +
 rtl/serial_adder_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: state encodings and default operand width.
package serial_adder_ctrl_pkg;

    localparam int unsigned SA_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sa_state_e;

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Purely combinational 1-bit full adder cell driven serially by serial_adder_ctrl.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: shifts operands LSB-first through one fa_cell.
// Optional build macro SERIAL_ADD_OVF_EN adds a two's-complement overflow output.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             overflow,
`endif
    output logic             carry_out
);

    localparam int unsigned CW = $clog2(WIDTH);

    sa_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_sr_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q, carry_out_q;
    logic             fa_s, fa_co;
    logic             last_bit;
    logic [WIDTH-1:0] sum_next;

    fa_cell u_fa (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (c_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign sum_next = {fa_s, sum_sr_q[WIDTH-1:1]};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_SHIFT: busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            ovf_q <= 1'b0;
        end else if (state_q == ST_SHIFT && last_bit) begin
            // c_q is the carry into the MSB at the final bit
            ovf_q <= c_q ^ fa_co;
        end
    end

    assign overflow = ovf_q;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            sum_sr_q    <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            c_q         <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sr_q      <= op_a;
                        b_sr_q      <= op_b;
                        c_q         <= carry_in;
                        cnt_q       <= '0;
                        sum_sr_q    <= '0;
                        sum_q       <= '0;
                        carry_out_q <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    sum_sr_q <= sum_next;
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    c_q      <= fa_co;
                    if (last_bit) begin
                        sum_q       <= sum_next;
                        carry_out_q <= fa_co;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_out_q;

endmodule
